vexriscv_bus_arbiter: RTL and testbench

Shares a single memory port between the VexRiscv instruction bus (iBus) and data bus (dBus) in the formal and simulation harnesses. Accepted commands are merged onto one cmd/rsp port. An in-order source FIFO tracks outstanding reads so that each response is routed back to the bus that issued it. The block sits between the VexRiscv instance and the memory model, and carries a sticky protocol-violation flag for assertions.

---
 rtl/vexriscv_arb_pkg.sv | 17 +
 rtl/vexriscv_arb_src_fifo.sv | 60 ++++++
 rtl/vexriscv_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vexriscv_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vexriscv_arb_pkg.sv
// Shared types for the VexRiscv iBus/dBus memory-port arbiter.
package vexriscv_arb_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/vexriscv_arb_src_fifo.sv
// In-order FIFO of the source (iBus/dBus) of every outstanding read.
module vexriscv_arb_src_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pushSrc_i,
  input  logic             pop_i,
  output logic             headSrc_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             pushOk, popOk;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign headSrc_o = mem_q[rdPtr_q];
  assign pushOk    = push_i && !full_o;
  assign popOk     = pop_i && !empty_o;

  // A push and pop in the same cycle advance both pointers and leave the count alone.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushSrc_i;
        wrPtr_q        <= nextPtr(wrPtr_q);
      end
      if (popOk) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      if (pushOk && !popOk) begin
        count_q <= count_q + 1'b1;
      end else if (!pushOk && popOk) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vexriscv_bus_arbiter.sv
// Merges VexRiscv iBus and dBus onto one memory port and routes responses back in order.
// Define VEXRISCV_ARB_ROUND_ROBIN_EN for alternating arbitration; default is fixed dBus priority.
module vexriscv_bus_arbiter
  import vexriscv_arb_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         iBus_cmd_valid,
  output logic                         iBus_cmd_ready,
  input  logic [31:0]                  iBus_cmd_payload_pc,
  output logic                         iBus_rsp_ready,
  output logic [31:0]                  iBus_rsp_inst,
  output logic                         iBus_rsp_error,
  input  logic                         dBus_cmd_valid,
  output logic                         dBus_cmd_ready,
  input  logic                         dBus_cmd_payload_wr,
  input  logic [31:0]                  dBus_cmd_payload_address,
  input  logic [31:0]                  dBus_cmd_payload_data,
  input  logic [1:0]                   dBus_cmd_payload_size,
  output logic                         dBus_rsp_ready,
  output logic [31:0]                  dBus_rsp_data,
  output logic                         dBus_rsp_error,
  output logic                         mem_cmd_valid,
  input  logic                         mem_cmd_ready,
  output logic                         mem_cmd_payload_wr,
  output logic [31:0]                  mem_cmd_payload_address,
  output logic [31:0]                  mem_cmd_payload_data,
  output logic [1:0]                   mem_cmd_payload_size,
  input  logic                         mem_rsp_valid,
  input  logic [31:0]                  mem_rsp_data,
  input  logic                         mem_rsp_error,
  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         proto_err
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  arb_state_e       state_q;
  logic             protoErr_q;
  logic             iReq, dReq, grantValid, cmdFire, isRead, rspStray;
  src_e             winner, grantSrc, headSrc;
  logic             srcHead, srcEmpty, srcFull;
  logic [CNT_W-1:0] srcCount;

  vexriscv_arb_src_fifo #(
    .DEPTH (MAX_PENDING),
    .CNT_W (CNT_W)
  ) u_srcFifo (
    .clock     (clock),
    .resetn    (resetn),
    .push_i    (cmdFire && isRead),
    .pushSrc_i (grantSrc == SRC_D),
    .pop_i     (resetn && mem_rsp_valid),
    .headSrc_o (srcHead),
    .count_o   (srcCount),
    .empty_o   (srcEmpty),
    .full_o    (srcFull)
  );

  assign headSrc = src_e'(srcHead);

`ifdef VEXRISCV_ARB_ROUND_ROBIN_EN
  src_e lastGrant_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lastGrant_q <= SRC_I;
    end else if (cmdFire) begin
      lastGrant_q <= grantSrc;
    end
  end

  always_comb begin
    if (iReq && dReq) begin
      winner = (lastGrant_q == SRC_D) ? SRC_I : SRC_D;
    end else begin
      winner = dReq ? SRC_D : SRC_I;
    end
  end
`else
  always_comb begin
    winner = dReq ? SRC_D : SRC_I;
  end
`endif

  // Reads are held off while the source FIFO is full; writes are never gated.
  always_comb begin
    iReq       = iBus_cmd_valid && !srcFull;
    dReq       = dBus_cmd_valid && (dBus_cmd_payload_wr || !srcFull);
    grantValid = 1'b0;
    grantSrc   = SRC_I;
    case (state_q)
      IDLE: begin
        grantValid = iReq || dReq;
        grantSrc   = winner;
      end
      LOCK_I: begin
        grantValid = iBus_cmd_valid;
        grantSrc   = SRC_I;
      end
      LOCK_D: begin
        grantValid = dBus_cmd_valid;
        grantSrc   = SRC_D;
      end
      default: begin
        grantValid = 1'b0;
        grantSrc   = SRC_I;
      end
    endcase
    cmdFire  = resetn && grantValid && mem_cmd_ready;
    isRead   = (grantSrc == SRC_I) || !dBus_cmd_payload_wr;
    rspStray = mem_rsp_valid && srcEmpty;
  end

  always_comb begin
    mem_cmd_valid           = resetn && grantValid;
    mem_cmd_payload_wr      = 1'b0;
    mem_cmd_payload_address = '0;
    mem_cmd_payload_data    = '0;
    mem_cmd_payload_size    = '0;
    iBus_cmd_ready          = 1'b0;
    dBus_cmd_ready          = 1'b0;
    if (mem_cmd_valid) begin
      if (grantSrc == SRC_D) begin
        mem_cmd_payload_wr      = dBus_cmd_payload_wr;
        mem_cmd_payload_address = dBus_cmd_payload_address;
        mem_cmd_payload_data    = dBus_cmd_payload_data;
        mem_cmd_payload_size    = dBus_cmd_payload_size;
        dBus_cmd_ready          = mem_cmd_ready;
      end else begin
        mem_cmd_payload_address = iBus_cmd_payload_pc;
        mem_cmd_payload_size    = SIZE_WORD;
        iBus_cmd_ready          = mem_cmd_ready;
      end
    end
  end

  always_comb begin
    iBus_rsp_ready = 1'b0;
    iBus_rsp_inst  = '0;
    iBus_rsp_error = 1'b0;
    dBus_rsp_ready = 1'b0;
    dBus_rsp_data  = '0;
    dBus_rsp_error = 1'b0;
    if (resetn && mem_rsp_valid && !srcEmpty) begin
      if (headSrc == SRC_D) begin
        dBus_rsp_ready = 1'b1;
        dBus_rsp_data  = mem_rsp_data;
        dBus_rsp_error = mem_rsp_error;
      end else begin
        iBus_rsp_ready = 1'b1;
        iBus_rsp_inst  = mem_rsp_data;
        iBus_rsp_error = mem_rsp_error;
      end
    end
  end

  assign pending_count = resetn ? srcCount : '0;
  assign proto_err     = resetn && protoErr_q;

  // A refused winner locks the grant so the held payload cannot be swapped mid-handshake.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      protoErr_q <= 1'b0;
    end else begin
      if (rspStray) begin
        protoErr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grantValid && !mem_cmd_ready) begin
            state_q <= (grantSrc == SRC_D) ? LOCK_D : LOCK_I;
          end
        end
        LOCK_I, LOCK_D: begin
          if (cmdFire) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
// Directed self-checking bench for vexriscv_bus_arbiter (MAX_PENDING = 4).
module tb_vexriscv_bus_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        iBus_cmd_valid, iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_error;
  logic [31:0] iBus_cmd_payload_pc, iBus_rsp_inst;
  logic        dBus_cmd_valid, dBus_cmd_ready, dBus_cmd_payload_wr, dBus_rsp_ready, dBus_rsp_error;
  logic [31:0] dBus_cmd_payload_address, dBus_cmd_payload_data, dBus_rsp_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_payload_wr;
  logic [31:0] mem_cmd_payload_address, mem_cmd_payload_data;
  logic [1:0]  mem_cmd_payload_size;
  logic        mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_rsp_data;
  logic [2:0]  pending_count;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  vexriscv_bus_arbiter #(.MAX_PENDING(4)) dut (
    .clock                    (clock),
    .resetn                   (resetn),
    .iBus_cmd_valid           (iBus_cmd_valid),
    .iBus_cmd_ready           (iBus_cmd_ready),
    .iBus_cmd_payload_pc      (iBus_cmd_payload_pc),
    .iBus_rsp_ready           (iBus_rsp_ready),
    .iBus_rsp_inst            (iBus_rsp_inst),
    .iBus_rsp_error           (iBus_rsp_error),
    .dBus_cmd_valid           (dBus_cmd_valid),
    .dBus_cmd_ready           (dBus_cmd_ready),
    .dBus_cmd_payload_wr      (dBus_cmd_payload_wr),
    .dBus_cmd_payload_address (dBus_cmd_payload_address),
    .dBus_cmd_payload_data    (dBus_cmd_payload_data),
    .dBus_cmd_payload_size    (dBus_cmd_payload_size),
    .dBus_rsp_ready           (dBus_rsp_ready),
    .dBus_rsp_data            (dBus_rsp_data),
    .dBus_rsp_error           (dBus_rsp_error),
    .mem_cmd_valid            (mem_cmd_valid),
    .mem_cmd_ready            (mem_cmd_ready),
    .mem_cmd_payload_wr       (mem_cmd_payload_wr),
    .mem_cmd_payload_address  (mem_cmd_payload_address),
    .mem_cmd_payload_data     (mem_cmd_payload_data),
    .mem_cmd_payload_size     (mem_cmd_payload_size),
    .mem_rsp_valid            (mem_rsp_valid),
    .mem_rsp_data             (mem_rsp_data),
    .mem_rsp_error            (mem_rsp_error),
    .pending_count            (pending_count),
    .proto_err                (proto_err)
  );

  always #5 clock = ~clock;

  // Inputs change just after the falling edge; outputs are sampled 1ns later, far from the rising edge.
  task automatic applyStimulus(input logic rstn, input logic iv, input logic [31:0] pc,
                               input logic dv, input logic dwr, input logic [31:0] daddr,
                               input logic [31:0] ddata, input logic mready,
                               input logic rv, input logic [31:0] rdata);
    @(negedge clock);
    resetn                   = rstn;
    iBus_cmd_valid           = iv;
    iBus_cmd_payload_pc      = pc;
    dBus_cmd_valid           = dv;
    dBus_cmd_payload_wr      = dwr;
    dBus_cmd_payload_address = daddr;
    dBus_cmd_payload_data    = ddata;
    mem_cmd_ready            = mready;
    mem_rsp_valid            = rv;
    mem_rsp_data             = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dBus_cmd_payload_size = 2'b10;
    mem_rsp_error         = 1'b0;

    // Reset: every output forced low even with requests pending
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b1, 32'h5);
    checkOutput("rst_mem_valid", 32'(mem_cmd_valid), 32'h0);
    checkOutput("rst_i_ready", 32'(iBus_cmd_ready), 32'h0);
    checkOutput("rst_d_ready", 32'(dBus_cmd_ready), 32'h0);
    checkOutput("rst_i_rsp", 32'(iBus_rsp_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("rst_pending", 32'(pending_count), 32'h0);
    checkOutput("rst_proto", 32'(proto_err), 32'h0);

    // Both request: dBus first, iBus next cycle
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tie_addr_d", mem_cmd_payload_address, 32'h2000);
    checkOutput("tie_d_ready", 32'(dBus_cmd_ready), 32'h1);
    checkOutput("tie_i_ready0", 32'(iBus_cmd_ready), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tie_addr_i", mem_cmd_payload_address, 32'h100);
    checkOutput("tie_i_size", 32'(mem_cmd_payload_size), 32'h2);
    checkOutput("tie_i_ready", 32'(iBus_cmd_ready), 32'h1);
    idleCycle();
    checkOutput("tie_pending", 32'(pending_count), 32'h2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11);
    checkOutput("tie_rsp_d", 32'(dBus_rsp_ready), 32'h1);
    checkOutput("tie_rsp_d_data", dBus_rsp_data, 32'h11);
    checkOutput("tie_rsp_i_idle", 32'(iBus_rsp_ready), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22);
    checkOutput("tie_rsp_i_data", iBus_rsp_inst, 32'h22);
    checkOutput("tie_rsp_d_zero", dBus_rsp_data, 32'h0);
    idleCycle();
    checkOutput("tie_drained", 32'(pending_count), 32'h0);

    // dBus write stalled 3 cycles: payload held, iBus locked out
    dBus_cmd_payload_size = 2'b01;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEAD, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("lockd_addr%0d", c), mem_cmd_payload_address, 32'h40);
      checkOutput($sformatf("lockd_i_ready%0d", c), 32'(iBus_cmd_ready), 32'h0);
    end
    checkOutput("lockd_data", mem_cmd_payload_data, 32'hDEAD);
    checkOutput("lockd_wr", 32'(mem_cmd_payload_wr), 32'h1);
    checkOutput("lockd_size", 32'(mem_cmd_payload_size), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEAD, 1'b1, 1'b0, 32'h0);
    checkOutput("lockd_accept", 32'(dBus_cmd_ready), 32'h1);
    dBus_cmd_payload_size = 2'b10;
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("lockd_then_i", mem_cmd_payload_address, 32'h200);
    checkOutput("lockd_write_nopush", 32'(pending_count), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h33);
    checkOutput("lockd_rsp_i", iBus_rsp_inst, 32'h33);

    // Fill to MAX_PENDING with iBus reads, then check gating
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("fill_i_ready%0d", k), 32'(iBus_cmd_ready), 32'h1);
    end
    applyStimulus(1'b1, 1'b1, 32'h310, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_pending", 32'(pending_count), 32'h4);
    checkOutput("full_i_gated", 32'(iBus_cmd_ready), 32'h0);
    checkOutput("full_no_valid", 32'(mem_cmd_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h310, 1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_d_read_gated", 32'(mem_cmd_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h310, 1'b1, 1'b1, 32'h80, 32'h77, 1'b1, 1'b0, 32'h0);
    checkOutput("full_d_write", 32'(dBus_cmd_ready), 32'h1);
    checkOutput("full_d_write_addr", mem_cmd_payload_address, 32'h80);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA0 + 32'(k));
      checkOutput($sformatf("drain_pending%0d", k), 32'(pending_count), 32'(4 - k));
      checkOutput($sformatf("drain_inst%0d", k), iBus_rsp_inst, 32'hA0 + 32'(k));
    end

    // Order I, D, I with responses A, B(error), C
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA);
    checkOutput("ord_pending", 32'(pending_count), 32'h3);
    checkOutput("ord_a_inst", iBus_rsp_inst, 32'hA);
    checkOutput("ord_a_d_idle", 32'(dBus_rsp_ready), 32'h0);
    mem_rsp_error = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hB);
    checkOutput("ord_b_data", dBus_rsp_data, 32'hB);
    checkOutput("ord_b_err", 32'(dBus_rsp_error), 32'h1);
    checkOutput("ord_b_i_idle", 32'(iBus_rsp_ready), 32'h0);
    mem_rsp_error = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC);
    checkOutput("ord_c_inst", iBus_rsp_inst, 32'hC);
    checkOutput("ord_c_err", 32'(iBus_rsp_error), 32'h0);

    // Push and pop in the same cycle at pending_count = 2
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h604, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h608, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h55);
    checkOutput("pp_before", 32'(pending_count), 32'h2);
    checkOutput("pp_rsp_d", dBus_rsp_data, 32'h55);
    checkOutput("pp_i_accept", 32'(iBus_cmd_ready), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h66);
    checkOutput("pp_after", 32'(pending_count), 32'h2);
    checkOutput("pp_rsp_i1", 32'(iBus_rsp_ready), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
    checkOutput("pp_rsp_i2", iBus_rsp_inst, 32'h77);

    // iBus refused then dBus write arrives: grant stays locked on iBus
    applyStimulus(1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("locki_valid", 32'(mem_cmd_valid), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 32'h44, 32'h1, 1'b0, 1'b0, 32'h0);
    checkOutput("locki_addr", mem_cmd_payload_address, 32'h700);
    applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 32'h44, 32'h1, 1'b1, 1'b0, 32'h0);
    checkOutput("locki_i_ready", 32'(iBus_cmd_ready), 32'h1);
    checkOutput("locki_d_ready", 32'(dBus_cmd_ready), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h1, 1'b1, 1'b0, 32'h0);
    checkOutput("locki_then_d", mem_cmd_payload_address, 32'h44);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h88);
    checkOutput("locki_rsp", iBus_rsp_inst, 32'h88);

    // Reset with 3 reads pending, then a stray response
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h800 + 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    idleCycle();
    checkOutput("rr_pending3", 32'(pending_count), 32'h3);
    checkOutput("rr_proto0", 32'(proto_err), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rr_in_reset_ready", 32'(iBus_cmd_ready), 32'h0);
    idleCycle();
    checkOutput("rr_pending0", 32'(pending_count), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99);
    checkOutput("rr_stray_i", 32'(iBus_rsp_ready), 32'h0);
    checkOutput("rr_stray_d", 32'(dBus_rsp_ready), 32'h0);
    idleCycle();
    checkOutput("rr_proto1", 32'(proto_err), 32'h1);
    checkOutput("rr_count_stays0", 32'(pending_count), 32'h0);
    idleCycle();
    checkOutput("rr_proto_sticky", 32'(proto_err), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
